// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks out one command
// byte (start, 8 data LSB first, odd parity, stop) on device-driven falling
// edges, then checks the device ACK. Outputs are open-collector enables.
// Optional build macro: PS2_TX_RETRY_EN (automatic resend after NACK/timeout).
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int MAX_RETRY      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int CW = (TW > IW) ? TW : IW;
   localparam int FW = $clog2(FILTER_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_SEND, S_WAIT_IDLE, S_FAIL} state_t;

   // bit 0 = ps2_clk, bit 1 = ps2_data
   logic [1:0] raw_in;
   logic [1:0] filt;
   assign raw_in = {ps2_data_in, ps2_clk_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_in
         logic          s1_q, s2_q, f_q;
         logic [FW-1:0] fcnt_q;
         // Synchronize, then only accept a new level after FILTER_CYCLES equal samples
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_q   <= 1'b1;
               s2_q   <= 1'b1;
               f_q    <= 1'b1;
               fcnt_q <= '0;
            end else begin
               s1_q <= raw_in[gi];
               s2_q <= s1_q;
               if (s2_q == f_q) begin
                  fcnt_q <= '0;
               end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
                  f_q    <= s2_q;
                  fcnt_q <= '0;
               end else begin
                  fcnt_q <= fcnt_q + 1'b1;
               end
            end
         end
         assign filt[gi] = f_q;
      end
   endgenerate

   logic filt_clk, filt_data;
   assign filt_clk  = filt[0];
   assign filt_data = filt[1];

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic          par_q, par_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          clk_prev_q;

   logic clk_fall, accept, nack_hit, tout_hit, retry_ok;

   assign clk_fall = clk_prev_q & ~filt_clk;
   assign accept   = (state_q == S_IDLE) && tx_valid && tx_ready;
   assign nack_hit = (state_q == S_SEND) && clk_fall && (bit_idx_q == 4'd10) && filt_data;
   assign tout_hit = ((state_q == S_SEND) || (state_q == S_WAIT_IDLE) || (state_q == S_FAIL))
                     && (cnt_q == CW'(TIMEOUT_CYCLES));

`ifdef PS2_TX_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] retry_q, retry_d;
   assign retry_ok = (retry_q < RW'(MAX_RETRY));

   // Retry count: cleared on accept, bumped on every failure that is retried
   always_comb begin
      retry_d = retry_q;
      if (accept) begin
         retry_d = '0;
      end else if ((nack_hit || tout_hit) && retry_ok) begin
         retry_d = retry_q + 1'b1;
      end
   end

   // Retry count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retry_q <= '0;
      else        retry_q <= retry_d;
   end
`else
   assign retry_ok = 1'b0;
`endif

   // State and output registers; reset releases both lines at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         par_q      <= 1'b0;
         bit_idx_q  <= '0;
         cnt_q      <= '0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'd0;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         par_q      <= par_d;
         bit_idx_q  <= bit_idx_d;
         cnt_q      <= cnt_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         clk_prev_q <= filt_clk;
      end
   end

   // Next-state logic; failures (NACK/watchdog) override the per-state action
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      par_d      = par_q;
      bit_idx_d  = bit_idx_q;
      cnt_d      = cnt_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d     = tx_data;
               par_d      = ~^tx_data;
               err_code_d = 2'd0;
               bit_idx_d  = '0;
               cnt_d      = '0;
               clk_oe_d   = 1'b1;
               data_oe_d  = 1'b0;
               state_d    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            cnt_d = cnt_q + 1'b1;
            // registered, so raising it one count early lands it on the last inhibit cycle
            if (cnt_q == CW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q < 4'd8)       data_oe_d = ~data_q[bit_idx_q[2:0]];
               else if (bit_idx_q == 4'd8) data_oe_d = ~par_q;
               else if (bit_idx_q == 4'd9) data_oe_d = 1'b0;
               else if (!filt_data)        state_d   = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            cnt_d = cnt_q + 1'b1;
            if (filt_clk && filt_data) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_FAIL: begin
            cnt_d = cnt_q + 1'b1;
            if (filt_clk && filt_data) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (nack_hit || tout_hit) begin
         done_d    = 1'b0;
         data_oe_d = 1'b0;
         if (retry_ok) begin
            state_d   = S_INHIBIT;
            cnt_d     = '0;
            bit_idx_d = '0;
            clk_oe_d  = 1'b1;
            error_d   = 1'b0;
         end else if (tout_hit) begin
            clk_oe_d   = 1'b0;
            err_code_d = (err_code_q == 2'd1) ? 2'd1 : 2'd2;
            error_d    = 1'b1;
            state_d    = S_IDLE;
         end else begin
            clk_oe_d   = 1'b0;
            err_code_d = 2'd1;
            state_d    = S_FAIL;
         end
      end
   end

   assign tx_ready    = (state_q == S_IDLE) && !done_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = done_q;
   assign tx_error    = error_q;
   assign err_code    = err_code_q;

endmodule
